inst_decode_queue: RTL

INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/inst_decode_queue_imm_gen.sv | 23 ++
 rtl/inst_decode_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32 decode definitions: major-opcode constants, immediate formats
// and the opcode-to-immediate-format mapping.
package cpu_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [4:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/inst_decode_queue_imm_gen.sv
// Combinational RV32 immediate generator: selects the immediate layout from
// the major opcode and sign-extends from inst[31].
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  // Assemble the immediate for the format implied by the opcode
  always_comb begin
    imm = 32'h0000_0000;
    case (imm_type_of(inst[6:2]))
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/inst_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of (inst, pc) whose
// head entry is decoded combinationally into RV32 fields.
module inst_decode_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit EN_MUL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_opcode,
  output logic [2:0]                 out_func3,
  output logic                       out_func7,
  output logic                       out_func7_mul,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_imm,
  output logic [31:0]                out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   head_inst_s;
  logic          opcode_ok_s;
  logic          mul_bad_s;

  assign in_ready  = (count_r < CW'(DEPTH));
  assign out_valid = (count_r != {CW{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign count     = count_r;

  // Storage array; flushed or reset entries simply become unreachable
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= in_inst;
      pc_mem_r[wr_ptr_r]   <= in_pc;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides any same-cycle push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_inst_s   = inst_mem_r[rd_ptr_r];
  assign out_pc        = pc_mem_r[rd_ptr_r];
  assign out_opcode    = head_inst_s[6:2];
  assign out_func3     = head_inst_s[14:12];
  assign out_func7     = head_inst_s[30];
  assign out_func7_mul = EN_MUL ? head_inst_s[25] : 1'b0;
  assign out_rs1       = head_inst_s[19:15];
  assign out_rs2       = head_inst_s[24:20];
  assign out_rd        = head_inst_s[11:7];

  imm_gen u_imm_gen (
    .inst (head_inst_s),
    .imm  (out_imm)
  );

  // Recognise the supported major opcodes
  always_comb begin
    opcode_ok_s = 1'b0;
    case (head_inst_s[6:2])
      OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_R,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: opcode_ok_s = 1'b1;
      default:                                       opcode_ok_s = 1'b0;
    endcase
  end

  // Without the M extension, any R-type with funct7[0] set is unsupported
  assign mul_bad_s   = !EN_MUL && (head_inst_s[6:2] == OP_R) && head_inst_s[25];
  assign out_illegal = (head_inst_s[1:0] != 2'b11) || !opcode_ok_s || mul_bad_s;

endmodule
